// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline stall/flush/halt sequencer.
package pipeline_sequencer_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } seq_state_e;

  // Default timing parameters
  localparam int unsigned LOAD_STALL_DEF   = 1;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned MEM_TIMEOUT_DEF  = 15;

  // Instruction-level constants shared with the decoder
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [3:0]  OP_LOAD   = 4'h8;
  localparam logic [3:0]  OP_HALT   = 4'hF;

  // Per-stage control bundle driven by the sequencer
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic memwb_bubble;
  } stage_ctrl_t;

  // wr=1: every stage advances normally; wr=0: everything frozen and NOPs injected
  function automatic stage_ctrl_t ctrl_all(input logic wr);
    stage_ctrl_t c;
    c.pc_write     = wr;
    c.ifid_write   = wr;
    c.ifid_flush   = ~wr;
    c.idex_write   = wr;
    c.idex_bubble  = ~wr;
    c.exmem_write  = wr;
    c.memwb_bubble = ~wr;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Stage-info inputs and per-stage control outputs of the sequencer.
interface pipeline_sequencer_if;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_halt;
  logic       id_redirect;
  logic       ex_load;
  logic [3:0] ex_rd;
  logic       mem_access;
  logic       mem_ready;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_bubble;
  logic       exmem_write;
  logic       memwb_bubble;
  logic       halted;
  logic       mem_timeout;

  // Pipeline/control side: supplies decoded stage info, consumes controls
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt, id_redirect,
           ex_load, ex_rd, mem_access, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, memwb_bubble, halted, mem_timeout
  );

  // Sequencer side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt, id_redirect,
           ex_load, ex_rd, mem_access, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, memwb_bubble, halted, mem_timeout
  );
endinterface

// File: rtl/pipeline_sequencer_hazard_compare.sv
// Combinational match of the EX destination against the ID sources; R0 never matches.
module pipeline_sequencer_hazard_compare (
  input  logic [3:0] id_rs1_i,
  input  logic [3:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [3:0] ex_rd_i,
  output logic       match_o
);
  logic [1:0][3:0] src;
  logic [1:0]      use_v;
  logic [1:0]      hit;

  assign src[0]   = id_rs1_i;
  assign src[1]   = id_rs2_i;
  assign use_v[0] = id_use_rs1_i;
  assign use_v[1] = id_use_rs2_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hit[gi] = use_v[gi] & (src[gi] == ex_rd_i);
    end
  endgenerate

  assign match_o = (|hit) & (ex_rd_i != 4'd0);
endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush/halt sequencer for the 5-stage pipeline.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_STALL   = LOAD_STALL_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_sequencer_if.slave  seq_if
);

  seq_state_e  state_q, state_d;
  logic [1:0]  stall_cnt_q, stall_cnt_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        halted_q, halted_d;
  logic        timeout_q, timeout_d;
  logic        reg_match;
  logic        load_use;
  logic        mem_wait;
  stage_ctrl_t ctrl;

  pipeline_sequencer_hazard_compare u_hazard (
    .id_rs1_i     (seq_if.id_rs1),
    .id_rs2_i     (seq_if.id_rs2),
    .id_use_rs1_i (seq_if.id_use_rs1),
    .id_use_rs2_i (seq_if.id_use_rs2),
    .ex_rd_i      (seq_if.ex_rd),
    .match_o      (reg_match)
  );

  assign load_use = seq_if.ex_load & reg_match;
  assign mem_wait = seq_if.mem_access & ~seq_if.mem_ready;

  // State, counters and sticky status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 2'd0;
      drain_cnt_q <= 4'd0;
      wait_cnt_q  <= 4'd0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next state: a memory wait freezes everything except the wait counter
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    drain_cnt_d = drain_cnt_q;
    wait_cnt_d  = 4'd0;
    timeout_d   = timeout_q;
    if (state_q != ST_HALTED) begin
      if (mem_wait) begin
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (wait_cnt_q == 4'(MEM_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_HALTED;
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            if (load_use) begin
              if (LOAD_STALL > 1) begin
                state_d     = ST_LDSTALL;
                stall_cnt_d = 2'(LOAD_STALL - 1);
              end
            end else if (!seq_if.id_redirect && seq_if.id_halt) begin
              state_d     = ST_DRAIN;
              drain_cnt_d = 4'(DRAIN_CYCLES);
            end
          end
          ST_LDSTALL: begin
            stall_cnt_d = stall_cnt_q - 2'd1;
            if (stall_cnt_q == 2'd1) state_d = ST_RUN;
          end
          ST_DRAIN: begin
            drain_cnt_d = drain_cnt_q - 4'd1;
            if (drain_cnt_q == 4'd1) state_d = ST_HALTED;
          end
          default: ;
        endcase
      end
    end
    halted_d = (state_d == ST_HALTED);
  end

  // Mealy stage controls; reset forces the NOP/frozen pattern immediately
  always_comb begin
    ctrl = ctrl_all(1'b1);
    if (rst || state_q == ST_HALTED) begin
      ctrl = ctrl_all(1'b0);
    end else if (mem_wait) begin
      ctrl.pc_write     = 1'b0;
      ctrl.ifid_write   = 1'b0;
      ctrl.idex_write   = 1'b0;
      ctrl.exmem_write  = 1'b0;
      ctrl.memwb_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_LDSTALL: begin
          ctrl.pc_write    = 1'b0;
          ctrl.ifid_write  = 1'b0;
          ctrl.idex_bubble = 1'b1;
        end
        ST_DRAIN: begin
          ctrl.pc_write    = 1'b0;
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_bubble = 1'b1;
        end
        default: begin
          if (load_use) begin
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_write  = 1'b0;
            ctrl.idex_bubble = 1'b1;
          end else if (seq_if.id_redirect) begin
            ctrl.ifid_flush = 1'b1;
          end else if (seq_if.id_halt) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
          end
        end
      endcase
    end
  end

  assign seq_if.pc_write     = ctrl.pc_write;
  assign seq_if.ifid_write   = ctrl.ifid_write;
  assign seq_if.ifid_flush   = ctrl.ifid_flush;
  assign seq_if.idex_write   = ctrl.idex_write;
  assign seq_if.idex_bubble  = ctrl.idex_bubble;
  assign seq_if.exmem_write  = ctrl.exmem_write;
  assign seq_if.memwb_bubble = ctrl.memwb_bubble;
  assign seq_if.halted       = halted_q;
  assign seq_if.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized and directed bench for pipeline_sequencer against a behavioural model.
module tb_pipeline_sequencer;
  localparam int LOAD_STALL   = 1;
  localparam int DRAIN_CYCLES = 3;
  localparam int MEM_TIMEOUT  = 15;

  logic clk = 1'b0;
  logic rst;
  pipeline_sequencer_if sif();

  pipeline_sequencer #(
    .LOAD_STALL   (LOAD_STALL),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .MEM_TIMEOUT  (MEM_TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (sif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles of pipeline history the spec rules leave pending
  int m_stall_left;  // further stall cycles owed after the first
  int m_drain_left;  // instructions still retiring after HALT (0 = not draining)
  int m_wait;        // consecutive memory-wait cycles
  bit m_stopped;
  bit m_timeout;

  task automatic check_eq(input string tag, input logic [8:0] actual, input logic [8:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic bit hazard();
    if (!sif.ex_load || sif.ex_rd == 4'd0) return 0;
    return (sif.id_use_rs1 && sif.id_rs1 == sif.ex_rd) ||
           (sif.id_use_rs2 && sif.id_rs2 == sif.ex_rd);
  endfunction

  function automatic bit waiting();
    return sif.mem_access && !sif.mem_ready;
  endfunction

  // {pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble, halted, timeout}
  function automatic logic [8:0] exp_vec();
    logic [6:0] c;
    if (rst || m_stopped)                       c = 7'b0010101;
    else if (waiting())                         c = 7'b0000001;
    else if (m_drain_left > 0)                  c = 7'b0111110;
    else if (m_stall_left > 0 || hazard())      c = 7'b0001110;
    else if (sif.id_redirect)                   c = 7'b1111010;
    else if (sif.id_halt)                       c = 7'b0001010;
    else                                        c = 7'b1101010;
    return {c, m_stopped, m_timeout};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {sif.pc_write, sif.ifid_write, sif.ifid_flush, sif.idex_write, sif.idex_bubble,
            sif.exmem_write, sif.memwb_bubble, sif.halted, sif.mem_timeout};
  endfunction

  task automatic model_reset();
    m_stall_left = 0;
    m_drain_left = 0;
    m_wait       = 0;
    m_stopped    = 0;
    m_timeout    = 0;
  endtask

  task automatic model_step();
    if (m_stopped) return;
    if (waiting()) begin
      m_wait++;
      if (m_wait >= MEM_TIMEOUT) begin
        m_timeout = 1;
        m_stopped = 1;
      end
      return;
    end
    m_wait = 0;
    if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_stopped = 1;
    end else if (m_stall_left > 0) begin
      m_stall_left--;
    end else if (hazard()) begin
      m_stall_left = LOAD_STALL - 1;
    end else if (!sif.id_redirect && sif.id_halt) begin
      m_drain_left = DRAIN_CYCLES;
    end
  endtask

  task automatic set_in(input logic [3:0] rs1, input logic [3:0] rs2, input logic u1, input logic u2,
                        input logic halt, input logic redir, input logic ld, input logic [3:0] rd,
                        input logic macc, input logic mrdy);
    sif.id_rs1 = rs1;  sif.id_rs2 = rs2;
    sif.id_use_rs1 = u1; sif.id_use_rs2 = u2;
    sif.id_halt = halt; sif.id_redirect = redir;
    sif.ex_load = ld; sif.ex_rd = rd;
    sif.mem_access = macc; sif.mem_ready = mrdy;
  endtask

  task automatic set_idle();
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge
  task automatic run_cycle(input string tag);
    #1 check_eq(tag, obs_vec(), exp_vec());
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1 check_eq(tag, obs_vec(), exp_vec());
    check_eq({tag, "_pat"}, obs_vec(), 9'b001010100);
    @(negedge clk);
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    int mrdy_pct;
    rst = 1'b1;
    set_idle();
    model_reset();
    @(negedge clk);
    do_reset("reset0");

    // 1: load-use on rs1
    set_in(4'd3, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
    #1 check_eq("t1_stall_pat", obs_vec(), 9'b000111000);
    run_cycle("t1_stall");
    set_in(4'd3, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    run_cycle("t1_resume");
    $display("scenario load_use done");

    // 2: no hazard with R0 or unused source
    set_in(4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    run_cycle("t2_r0");
    set_in(4'd3, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
    #1 check_eq("t2_nouse_pat", obs_vec(), 9'b110101000);
    run_cycle("t2_nouse");
    $display("scenario no_hazard done");

    // 3: redirect, then redirect colliding with load-use
    set_in(4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    run_cycle("t3_flush");
    set_idle();
    run_cycle("t3_after");
    set_in(4'd6, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1);
    run_cycle("t3_lu_redir");
    set_in(4'd6, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    #1 check_eq("t3_flush_next_pat", obs_vec(), 9'b111101000);
    run_cycle("t3_flush_next");
    $display("scenario redirect done");

    // 4: five memory wait cycles
    set_in(4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) run_cycle("t4_wait");
    sif.mem_ready = 1'b1;
    run_cycle("t4_resume");
    $display("scenario mem_wait done");

    // 5: halt drain with a mem wait in the middle
    set_idle();
    sif.id_halt = 1'b1;
    run_cycle("t5_entry");
    set_idle();
    run_cycle("t5_drain");
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    run_cycle("t5_wait");
    run_cycle("t5_wait");
    set_idle();
    run_cycle("t5_drain");
    #1 check_eq("t5_not_yet", {8'd0, sif.halted}, 9'd0);
    run_cycle("t5_drain");
    #1 check_eq("t5_halted", {8'd0, sif.halted}, 9'd1);
    run_cycle("t5_stop");
    $display("scenario halt_drain done");

    // 6: timeout, then reset mid-drain
    do_reset("t6_reset");
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) run_cycle("t6_wait");
    #1 check_eq("t6_no_to", {8'd0, sif.mem_timeout}, 9'd0);
    run_cycle("t6_wait");
    #1 check_eq("t6_to", {7'd0, sif.halted, sif.mem_timeout}, 9'b000000011);
    run_cycle("t6_stopped");
    do_reset("t6_reset2");
    sif.id_halt = 1'b1;
    run_cycle("t6_entry");
    set_idle();
    run_cycle("t6_drain");
    do_reset("t6_mid_drain_rst");
    run_cycle("t6_after_rst");
    $display("scenario timeout_reset done");

    // Randomized segments, each starting from reset
    for (int seg = 0; seg < 40; seg++) begin
      do_reset("rnd_reset");
      mrdy_pct = (seg % 5 == 0) ? 3 : 60;
      for (int cyc = 0; cyc < 50; cyc++) begin
        set_in(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 20),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
               1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < mrdy_pct));
        run_cycle("rnd");
      end
      $display("segment %0d done: halted=%0b timeout=%0b", seg, m_stopped, m_timeout);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
